// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline stall/flush sequencer
//
// Purpose: FSM state encodings and PC-source select values used by
// pipe_hazard_ctrl and any block that decodes its debug/select outputs.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_IMEM_WAIT = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_e;

  localparam logic [1:0] PC_SEL_NPC  = 2'd0;
  localparam logic [1:0] PC_SEL_BR   = 2'd1;
  localparam logic [1:0] PC_SEL_TRAP = 2'd2;
  localparam logic [1:0] PC_SEL_EPC  = 2'd3;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
//
// Purpose: flags an ID instruction that reads the destination of a load
// currently in EXE. x0 never creates a dependency.
// Ports:
//   valid_id_i  ID holds a valid instruction
//   rs1_id_i    ID source register 1
//   rs2_id_i    ID source register 2
//   load_exe_i  EXE holds a valid load
//   rd_exe_i    EXE destination register
//   load_use_o  dependent instruction must wait one cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  valid_id_i,
  input  logic [REG_ADDR_W-1:0] rs1_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_id_i,
  input  logic                  load_exe_i,
  input  logic [REG_ADDR_W-1:0] rd_exe_i,
  output logic                  load_use_o
);

  logic rd_nonzero;
  logic rd_match;

  assign rd_nonzero = (rd_exe_i != '0);
  assign rd_match   = (rd_exe_i == rs1_id_i) || (rd_exe_i == rs2_id_i);
  assign load_use_o = valid_id_i && load_exe_i && rd_nonzero && rd_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: drives stall/flush of IF_ID, ID_EXE, EXE_MEM, MEM_WB, the PC hold
// and the PC-source select. Priority: WB trap/return, dmem wait, imem wait,
// EXE branch redirect, load-use. Counts cycles with stall_pc=1 (saturating).
// Optional feature macro: DMEM_TIMEOUT_EN (dmem wait bounded by MEM_TIMEOUT,
// dmem_fault pulses on expiry; otherwise dmem_fault=0 and the wait is unbounded).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   valid_id, rs1_id, rs2_id      ID instruction and its sources
//   load_exe, rd_exe              load in EXE and its destination
//   imem_ready                    fetch data valid this cycle
//   dmem_req_mem, dmem_ready      MEM access outstanding / completing
//   br_redirect_exe               EXE branch redirect
//   except_happen_wb, ret_wb      WB trap / xRET
//   stall_*, flush_*              stage register controls (stall wins over flush)
//   pc_sel                        0 npc, 1 branch, 2 trap vector, 3 epc
//   state                         FSM state (debug)
//   stall_cycles                  saturating count of stall_pc cycles
//   dmem_fault                    one-cycle dmem timeout pulse
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  load_exe,
  input  logic [REG_ADDR_W-1:0] rd_exe,
  input  logic                  imem_ready,
  input  logic                  dmem_req_mem,
  input  logic                  dmem_ready,
  input  logic                  br_redirect_exe,
  input  logic                  except_happen_wb,
  input  logic                  ret_wb,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  stall_id_exe,
  output logic                  stall_exe_mem,
  output logic                  stall_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_exe,
  output logic                  flush_exe_mem,
  output logic                  flush_mem_wb,
  output logic [1:0]            pc_sel,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  dmem_fault
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              load_use;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
  logic fault_d;
`endif

  hazard_detect u_hazard_detect (
    .valid_id_i (valid_id),
    .rs1_id_i   (rs1_id),
    .rs2_id_i   (rs2_id),
    .load_exe_i (load_exe),
    .rd_exe_i   (rd_exe),
    .load_use_o (load_use)
  );

  always_comb begin
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_exe  = 1'b0;
    stall_exe_mem = 1'b0;
    stall_mem_wb  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_exe  = 1'b0;
    flush_exe_mem = 1'b0;
    flush_mem_wb  = 1'b0;
    pc_sel        = PC_SEL_NPC;
    state_d       = ST_RUN;
    // Any cycle that is not a continuing dmem wait clears the wait counter.
    wait_cnt_d    = '0;
`ifdef DMEM_TIMEOUT_EN
    fault_d       = 1'b0;
`endif

    if (rst) begin
      flush_if_id   = 1'b1;
      flush_id_exe  = 1'b1;
      flush_exe_mem = 1'b1;
      flush_mem_wb  = 1'b1;
    end else if (except_happen_wb || ret_wb) begin
      flush_if_id   = 1'b1;
      flush_id_exe  = 1'b1;
      flush_exe_mem = 1'b1;
      flush_mem_wb  = 1'b1;
      pc_sel        = except_happen_wb ? PC_SEL_TRAP : PC_SEL_EPC;
      state_d       = ST_REDIRECT;
    end else if (state_q == ST_REDIRECT) begin
      // The fetch issued in the trap cycle came from the old PC.
      flush_if_id = 1'b1;
    end else if (dmem_req_mem && !dmem_ready) begin
`ifdef DMEM_TIMEOUT_EN
      if ((state_q == ST_DMEM_WAIT) && (wait_cnt_q == TIMEOUT_VAL)) begin
        // Let the instruction reach WB so the trap logic reports the fault.
        fault_d = 1'b1;
      end else
`endif
      begin
        stall_pc      = 1'b1;
        stall_if_id   = 1'b1;
        stall_id_exe  = 1'b1;
        stall_exe_mem = 1'b1;
        flush_mem_wb  = 1'b1;
        state_d       = ST_DMEM_WAIT;
        wait_cnt_d    = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      end
    end else if (!imem_ready) begin
      flush_if_id = 1'b1;
      state_d     = ST_IMEM_WAIT;
      if (br_redirect_exe) begin
        // Redirect immediately; the ID instruction is wrong-path as well.
        pc_sel       = PC_SEL_BR;
        flush_id_exe = 1'b1;
      end else begin
        stall_pc = 1'b1;
        // Later stages advance, so a load-use consumer must still be held.
        if (load_use) begin
          stall_if_id  = 1'b1;
          flush_id_exe = 1'b1;
        end
      end
    end else if (br_redirect_exe) begin
      // The branch flush also removes any load-use consumer in ID.
      pc_sel       = PC_SEL_BR;
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (load_use) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cnt_q;

`ifdef DMEM_TIMEOUT_EN
  assign dmem_fault = fault_d;
`else
  assign dmem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             valid_id;
  logic [4:0]       rs1_id, rs2_id, rd_exe;
  logic             load_exe, imem_ready, dmem_req_mem, dmem_ready;
  logic             br_redirect_exe, except_happen_wb, ret_wb;
  logic             stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb;
  logic             flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb;
  logic [1:0]       pc_sel, state;
  logic [CNT_W-1:0] stall_cycles;
  logic             dmem_fault;
  logic [12:0]      dut_vec;

  typedef struct {
    string            tag;
    logic [12:0]      vec;
    logic [CNT_W-1:0] sc;
    logic             fault;
  } exp_t;

  exp_t             sbq[$];
  int               total = 0;
  int               bad = 0;
  logic [CNT_W-1:0] sc_exp = '0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .load_exe(load_exe), .rd_exe(rd_exe), .imem_ready(imem_ready),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .br_redirect_exe(br_redirect_exe), .except_happen_wb(except_happen_wb),
    .ret_wb(ret_wb), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .stall_id_exe(stall_id_exe), .stall_exe_mem(stall_exe_mem),
    .stall_mem_wb(stall_mem_wb), .flush_if_id(flush_if_id),
    .flush_id_exe(flush_id_exe), .flush_exe_mem(flush_exe_mem),
    .flush_mem_wb(flush_mem_wb), .pc_sel(pc_sel), .state(state),
    .stall_cycles(stall_cycles), .dmem_fault(dmem_fault)
  );

  assign dut_vec = {stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb,
                    flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb, pc_sel, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stalls {pc,if_id,id_exe,exe_mem,mem_wb}, flushes {if_id,id_exe,exe_mem,mem_wb}
  function automatic logic [12:0] mk(input logic [4:0] s, input logic [3:0] f,
                                     input logic [1:0] ps, input logic [1:0] st);
    return {s, f, ps, st};
  endfunction

  task automatic idle();
    rst = 1'b0; valid_id = 1'b1; rs1_id = 5'd1; rs2_id = 5'd2; rd_exe = 5'd0;
    load_exe = 1'b0; imem_ready = 1'b1; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
    br_redirect_exe = 1'b0; except_happen_wb = 1'b0; ret_wb = 1'b0;
  endtask

  // Inputs are driven at posedge+1; outputs are sampled at the falling edge.
  task automatic step(input string tag, input logic [12:0] e, input logic f);
    exp_t x;
    x.tag = tag; x.vec = e; x.sc = sc_exp; x.fault = f;
    sbq.push_back(x);
    #4;
    x = sbq.pop_front();
    total++;
    assert (dut_vec === x.vec) else begin
      bad++;
      $error("FAIL %s outputs: got %b want %b", x.tag, dut_vec, x.vec);
    end
    total++;
    assert (stall_cycles === x.sc) else begin
      bad++;
      $error("FAIL %s stall_cycles: got %0d want %0d", x.tag, stall_cycles, x.sc);
    end
    total++;
    assert (dmem_fault === x.fault) else begin
      bad++;
      $error("FAIL %s dmem_fault: got %b want %b", x.tag, dmem_fault, x.fault);
    end
    if (rst) sc_exp = '0;
    else if (e[12] && (sc_exp != '1)) sc_exp = sc_exp + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset", mk(5'b00000, 4'b1111, 2'd0, 2'd0), 1'b0);
    idle();
    step("idle", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);

    // load-use on rs2, then released
    load_exe = 1'b1; rd_exe = 5'd5; rs1_id = 5'd3; rs2_id = 5'd5;
    step("lu_rs2", mk(5'b11000, 4'b0100, 2'd0, 2'd0), 1'b0);
    idle();
    step("lu_after", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);
    load_exe = 1'b1; rd_exe = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
    step("lu_x0", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);
    load_exe = 1'b1; rd_exe = 5'd7; rs1_id = 5'd7;
    step("lu_rs1", mk(5'b11000, 4'b0100, 2'd0, 2'd0), 1'b0);
    valid_id = 1'b0;
    step("lu_invalid", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);
    idle();

    // dmem wait for 3 cycles
    dmem_req_mem = 1'b1;
    step("dm_w0", mk(5'b11110, 4'b0001, 2'd0, 2'd0), 1'b0);
    step("dm_w1", mk(5'b11110, 4'b0001, 2'd0, 2'd1), 1'b0);
    step("dm_w2", mk(5'b11110, 4'b0001, 2'd0, 2'd1), 1'b0);
    dmem_ready = 1'b1;
    step("dm_done", mk(5'b00000, 4'b0000, 2'd0, 2'd1), 1'b0);
    idle();
    step("dm_run", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);

    // branch beats load-use
    br_redirect_exe = 1'b1; load_exe = 1'b1; rd_exe = 5'd5; rs2_id = 5'd5;
    step("br_lu", mk(5'b00000, 4'b1100, 2'd1, 2'd0), 1'b0);
    idle();

    // imem wait
    imem_ready = 1'b0;
    step("im_w0", mk(5'b10000, 4'b1000, 2'd0, 2'd0), 1'b0);
    step("im_w1", mk(5'b10000, 4'b1000, 2'd0, 2'd2), 1'b0);
    idle();
    step("im_done", mk(5'b00000, 4'b0000, 2'd0, 2'd2), 1'b0);
    step("im_run", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);

    // trap during the second DMEM_WAIT cycle
    dmem_req_mem = 1'b1;
    step("tr_w0", mk(5'b11110, 4'b0001, 2'd0, 2'd0), 1'b0);
    step("tr_w1", mk(5'b11110, 4'b0001, 2'd0, 2'd1), 1'b0);
    except_happen_wb = 1'b1;
    step("tr_trap", mk(5'b00000, 4'b1111, 2'd2, 2'd1), 1'b0);
    idle();
    step("tr_redir", mk(5'b00000, 4'b1000, 2'd0, 2'd3), 1'b0);
    step("tr_run", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);

    // xRET, then trap+ret in REDIRECT, then reset mid-REDIRECT
    ret_wb = 1'b1;
    step("ret", mk(5'b00000, 4'b1111, 2'd3, 2'd0), 1'b0);
    except_happen_wb = 1'b1;
    step("trap_ret", mk(5'b00000, 4'b1111, 2'd2, 2'd3), 1'b0);
    idle();
    rst = 1'b1;
    step("rst_redir", mk(5'b00000, 4'b1111, 2'd0, 2'd3), 1'b0);
    idle();
    step("post_rst", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);
    load_exe = 1'b1; rd_exe = 5'd9; rs1_id = 5'd9;
    step("post_lu", mk(5'b11000, 4'b0100, 2'd0, 2'd0), 1'b0);
    idle();
    step("post_cnt", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);

`ifdef DMEM_TIMEOUT_EN
    // dmem_ready held low: fault on the 4th DMEM_WAIT cycle
    dmem_req_mem = 1'b1;
    step("to_w0", mk(5'b11110, 4'b0001, 2'd0, 2'd0), 1'b0);
    step("to_w1", mk(5'b11110, 4'b0001, 2'd0, 2'd1), 1'b0);
    step("to_w2", mk(5'b11110, 4'b0001, 2'd0, 2'd1), 1'b0);
    step("to_w3", mk(5'b11110, 4'b0001, 2'd0, 2'd1), 1'b0);
    step("to_fault", mk(5'b00000, 4'b0000, 2'd0, 2'd1), 1'b1);
    idle();
    step("to_run", mk(5'b00000, 4'b0000, 2'd0, 2'd0), 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
